// File: rtl/ysyx_24090018_pkg.sv
// Shared types for the writeback unit: FSM state encoding and the RV32I
// load funct3 encodings used by the load formatter.
package ysyx_24090018_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LSU = 1'b1
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_24090018_load_fmt.sv
// Combinational load-data formatter: selects the byte or half addressed by
// addr_lo from the LSU word and sign/zero extends it according to funct3.
module ysyx_24090018_load_fmt
  import ysyx_24090018_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_shift = rdata_i >> {addr_lo_i, 3'b000};
  // Halfword select ignores addr_lo[0]; misaligned halves never reach here.
  assign half_shift = rdata_i >> {addr_lo_i[1], 4'b0000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = half_shift[15:0];

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = rdata_i;
      F3_LBU:  data_o = {24'b0, byte_sel};
      F3_LHU:  data_o = {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/ysyx_24090018_wbu.sv
// Writeback unit: retires execute-stage results into the register file,
// waits for LSU data on loads, and tracks pending writers per register.
module ysyx_24090018_wbu
  import ysyx_24090018_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         in_wen_i,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rd_i,
  input  logic                         in_is_load_i,
  input  logic [2:0]                   in_funct3_i,
  input  logic [1:0]                   in_addr_lo_i,
  input  logic [DATA_WIDTH-1:0]        in_result_i,
  input  logic                         lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        lsu_rdata_i,
  output logic                         rf_wen_o,
  output logic [REG_ADDR_WIDTH-1:0]    rf_waddr_o,
  output logic [DATA_WIDTH-1:0]        rf_wdata_o,
  output logic                         commit_o,
  input  logic                         sb_set_i,
  input  logic [REG_ADDR_WIDTH-1:0]    sb_set_rd_i,
  output logic [2**REG_ADDR_WIDTH-1:0] busy_o
);

  localparam int NREGS = 2**REG_ADDR_WIDTH;

  wbu_state_e                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                      ld_wen_q, ld_wen_d;
  logic [2:0]                ld_funct3_q, ld_funct3_d;
  logic [1:0]                ld_addr_lo_q, ld_addr_lo_d;
  logic                      rf_wen_q, rf_wen_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
  logic                      commit_q, commit_d;
  logic [NREGS-1:0]          busy_q, busy_d;
  logic [31:0]               fmt_data;

  ysyx_24090018_load_fmt u_load_fmt (
    .funct3_i  (ld_funct3_q),
    .addr_lo_i (ld_addr_lo_q),
    .rdata_i   (lsu_rdata_i[31:0]),
    .data_o    (fmt_data)
  );

  assign in_ready_o = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    ld_rd_d      = ld_rd_q;
    ld_wen_d     = ld_wen_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    commit_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (in_is_load_i) begin
            ld_rd_d      = in_rd_i;
            ld_wen_d     = in_wen_i;
            ld_funct3_d  = in_funct3_i;
            ld_addr_lo_d = in_addr_lo_i;
            state_d      = WAIT_LSU;
          end else begin
            rf_wen_d   = in_wen_i & (in_rd_i != '0);
            rf_waddr_d = in_rd_i;
            rf_wdata_d = in_result_i;
            commit_d   = 1'b1;
          end
        end
      end
      WAIT_LSU: begin
        if (lsu_rvalid_i) begin
          rf_wen_d   = ld_wen_q & (ld_rd_q != '0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = DATA_WIDTH'(fmt_data);
          commit_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set beats clear on the same register: a newer writer is already in flight.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
      logic set_w, clr_w;
      assign set_w      = sb_set_i & (sb_set_rd_i == REG_ADDR_WIDTH'(gi));
      assign clr_w      = rf_wen_q & (rf_waddr_q == REG_ADDR_WIDTH'(gi));
      assign busy_d[gi] = set_w | (busy_q[gi] & ~clr_w);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ld_rd_q      <= '0;
      ld_wen_q     <= 1'b0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      commit_q     <= 1'b0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      ld_rd_q      <= ld_rd_d;
      ld_wen_q     <= ld_wen_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      commit_q     <= commit_d;
      busy_q       <= busy_d;
    end
  end

  assign rf_wen_o   = rf_wen_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign commit_o   = commit_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/ysyx_24090018_wbu.md
Name: ysyx_24090018_wbu

Overview:
Writeback unit: the stage directly upstream of the integer register file, driving its single write port (wdata/waddr/wen).
- Accepts completed instructions from the execute stage over a valid/ready handshake.
- For loads, waits for the LSU read response, then extracts, aligns and extends the load data.
- Keeps a per-register busy scoreboard that the decode stage uses for RAW-hazard stalls.

Parameters:
REG_ADDR_WIDTH, 4, register index width (16 registers, RV32E).
DATA_WIDTH, 32, register and data width.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  execute stage presents a completed instruction
in_ready_o  output  1  WBU can accept this cycle
in_wen_i  input  1  instruction writes rd
in_rd_i  input  REG_ADDR_WIDTH  destination register
in_is_load_i  input  1  result comes from LSU, not in_result_i
in_funct3_i  input  3  load type (RV32I funct3)
in_addr_lo_i  input  2  load address bits [1:0]
in_result_i  input  DATA_WIDTH  ALU/CSR/link result
lsu_rvalid_i  input  1  LSU read data valid (single-cycle pulse)
lsu_rdata_i  input  DATA_WIDTH  aligned 32-bit word containing the load data
rf_wen_o  output  1  register file write enable
rf_waddr_o  output  REG_ADDR_WIDTH  register file write address
rf_wdata_o  output  DATA_WIDTH  register file write data
commit_o  output  1  one-cycle pulse per retired instruction
sb_set_i  input  1  decode issues an instruction that will write rd
sb_set_rd_i  input  REG_ADDR_WIDTH  rd of the issued instruction
busy_o  output  2**REG_ADDR_WIDTH  per-register pending-write bits

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, commit_o=0, busy_o=all 0, captured load context cleared.
- Reset during WAIT_LSU: the pending load is dropped, with no write and no commit.
- FSM states are IDLE and WAIT_LSU.
  - in_ready_o = 1 in IDLE, 0 in WAIT_LSU. It is purely a function of state.
- IDLE, handshake (in_valid_i & in_ready_o), non-load:
  - Next cycle: rf_wen_o = in_wen_i & (in_rd_i != 0), rf_waddr_o = in_rd_i, rf_wdata_o = in_result_i, commit_o = 1.
  - State stays IDLE, so back-to-back non-loads retire one per cycle.
- IDLE, handshake, load:
  - Capture in_rd_i, in_wen_i, in_funct3_i and in_addr_lo_i; go to WAIT_LSU.
  - No write and no commit in the following cycle.
- WAIT_LSU:
  - Holds until lsu_rvalid_i = 1.
  - Next cycle: rf_wen_o = captured wen & rd != 0, rf_waddr_o = captured rd, rf_wdata_o = formatted data, commit_o = 1.
  - Then returns to IDLE.
  - Latency from LSU response to write is exactly 1 cycle.
- lsu_rvalid_i in IDLE is ignored.
- rf_wen_o and commit_o are single-cycle pulses. rf_waddr_o and rf_wdata_o hold their last value when rf_wen_o = 0.
- Load formatting (sh = addr_lo*8, hsel = addr_lo[1]*16):
  - 000 LB: sign-extend byte at bit sh.
  - 001 LH: sign-extend half at hsel (addr_lo[0] ignored; alignment is enforced upstream).
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Any other encoding: treated as LW.
- Scoreboard, per register r on each clock edge:
  - set: sb_set_i & sb_set_rd_i == r & r != 0.
  - clear: rf_wen_o & rf_waddr_o == r (the same edge at which the register file captures the write).
  - Set and clear on the same r in the same edge: set wins (a newer writer is in flight).
  - busy_o[0] is constant 0.
  - No counting: the decode stage never issues a second writer to a busy register.

Decomposition:
- Shared package ysyx_24090018_pkg holds:
  - wbu state enum (IDLE, WAIT_LSU);
  - load funct3 constants (LB, LH, LW, LBU, LHU).
- Sub-module ysyx_24090018_load_fmt: purely combinational funct3/addr_lo/rdata to formatted data; instantiated once.

Test Plan:
- Reset then non-load: in rd=5, result=0x12345678, wen=1 -> next cycle rf_wen_o=1, waddr=5, wdata=0x12345678, commit_o=1; following cycle rf_wen_o=0.
- rd=0 write: rd=0, wen=1, result=0xFFFFFFFF -> rf_wen_o=0, commit_o=1.
- LB: funct3=000, addr_lo=3, rdata=0x80FF0000, rd=7 -> in_ready_o=0 until rvalid; 1 cycle after rvalid, wdata=0xFFFFFF80, waddr=7, commit_o=1.
- Load variants on rdata=0x8001A5F0:
  - LHU addr_lo=2 -> 0x00008001
  - LH addr_lo=0 -> 0xFFFFA5F0
  - LBU addr_lo=1 -> 0x000000A5
  - LW -> 0x8001A5F0
- Scoreboard:
  - sb_set rd=9 -> busy_o[9]=1 next cycle; cleared after the rd=9 write edge.
  - Same-cycle sb_set rd=9 with rf_wen_o to 9 -> busy_o[9] stays 1.
  - sb_set rd=0 -> busy_o[0]=0.
- Async reset asserted mid-WAIT_LSU -> outputs 0 immediately; after release, in_ready_o=1; a late lsu_rvalid_i produces no write and no commit.
